// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct constants, next-PC branch classes and reset values.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [1:0] {
        BR_SEQ = 2'b00,
        BR_BEQ = 2'b01,
        BR_J   = 2'b10,
        BR_JR  = 2'b11
    } br_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/id_stage_if.sv
// IFU <-> decode and write-back signals of the decode stage.
interface id_stage_if;
    import mips_defs::*;

    logic [31:0] if_pc;
    logic [31:0] if_cmd;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic [15:0] imm16;
    logic [25:0] bits26;
    logic [31:0] ra;
    br_e         branch;
    logic        beqTrue;
    logic [31:0] id_pc;
    logic [31:0] id_cmd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] link_pc;

    // Driver side: IFU plus write-back.
    modport master (
        output if_pc, if_cmd, stall, flush, wb_we, wb_addr, wb_data, wb_pc,
        input  imm16, bits26, ra, branch, beqTrue, id_pc, id_cmd, rs_val, rt_val, link_pc
    );

    modport slave (
        input  if_pc, if_cmd, stall, flush, wb_we, wb_addr, wb_data, wb_pc,
        output imm16, bits26, ra, branch, beqTrue, id_pc, id_cmd, rs_val, rt_val, link_pc
    );
endinterface

// File: rtl/grf.sv
// 32x32 general register file: two combinational read ports with write-back
// bypass, one write port, $0 hardwired to zero.
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [31:0] wpc
);
    logic [31:0] regs [32];
    logic        wr_ok;

    assign wr_ok = we && (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
`ifndef SYNTHESIS
            $display("@%h: $%d <= %h", wpc, wa, wd);
`endif
        end
    end

    // Same-cycle write is forwarded so decode sees the value being retired.
    always_comb begin
        rd1 = 32'h0;
        rd2 = 32'h0;
        if (ra1 != 5'd0) rd1 = (wr_ok && wa == ra1) ? wd : regs[ra1];
        if (ra2 != 5'd0) rd2 = (wr_ok && wa == ra2) ? wd : regs[ra2];
    end

`ifdef SYNTHESIS
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif
endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID pipeline register, GRF read with bypass, and next-PC
// class / beq resolution returned to the IFU.
module id_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);
    logic [31:0] id_pc_q;
    logic [31:0] id_cmd_q;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_v;
    logic [31:0] rt_v;
    br_e         br;

    // Stall outranks flush: the held instruction still has to issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_pc_q  <= RESET_PC;
            id_cmd_q <= NOP_INSTR;
        end else if (bus.stall) begin
            id_pc_q  <= id_pc_q;
            id_cmd_q <= id_cmd_q;
        end else if (bus.flush) begin
            id_pc_q  <= RESET_PC;
            id_cmd_q <= NOP_INSTR;
        end else begin
            id_pc_q  <= bus.if_pc;
            id_cmd_q <= bus.if_cmd;
        end
    end

    grf u_grf (
        .clk   (clk),
        .reset (reset),
        .ra1   (id_cmd_q[25:21]),
        .ra2   (id_cmd_q[20:16]),
        .rd1   (rs_v),
        .rd2   (rt_v),
        .we    (bus.wb_we),
        .wa    (bus.wb_addr),
        .wd    (bus.wb_data),
        .wpc   (bus.wb_pc)
    );

    assign opcode = id_cmd_q[31:26];
    assign funct  = id_cmd_q[5:0];

    always_comb begin
        br = BR_SEQ;
        case (opcode)
            OP_BEQ:       br = BR_BEQ;
            OP_J, OP_JAL: br = BR_J;
            OP_RTYPE:     if (funct == FUNCT_JR) br = BR_JR;
            default:      br = BR_SEQ;
        endcase
    end

    assign bus.id_pc   = id_pc_q;
    assign bus.id_cmd  = id_cmd_q;
    assign bus.imm16   = id_cmd_q[15:0];
    assign bus.bits26  = id_cmd_q[25:0];
    assign bus.rs_val  = rs_v;
    assign bus.rt_val  = rt_v;
    assign bus.ra      = rs_v;
    assign bus.beqTrue = (rs_v == rt_v);
    assign bus.branch  = br;
    assign bus.link_pc = id_pc_q + 32'd8;
endmodule
